// File: rtl/pc_reg.sv
// pc_reg: program counter with previous-PC history, alignment flag and, when
// PC_TRACE_EN is defined, redirect classification, saturating load counters and a trace monitor.
module pc_reg #(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       STEP        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_prev,
  output logic             misaligned,
  output logic             redirect,
  output logic [WIDTH-1:0] seq_count,
  output logic [WIDTH-1:0] redir_count
);
  if (WIDTH < 2 || (WIDTH < 32 && (64'(STEP) >> WIDTH) != 64'd0)) begin : g_bad_cfg
    $error("pc_reg: WIDTH must be >= 2 and STEP must fit in WIDTH bits");
  end
  logic [WIDTH-1:0] pc_q, prev_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_VALUE;
      prev_q <= RESET_VALUE;
    end else begin
      pc_q   <= d;
      prev_q <= pc_q;
    end
  end
  assign q          = pc_q;
  assign q_prev     = prev_q;
  assign misaligned = |pc_q[1:0];
`ifdef PC_TRACE_EN
  logic             redir_d, redir_q;
  logic [WIDTH-1:0] seq_d, seq_q, rc_d, rc_q;
  // the add wraps modulo 2^WIDTH, so 0 after the top word counts as sequential
  always_comb begin
    redir_d = d != pc_q + WIDTH'(STEP);
    seq_d   = (!redir_d && seq_q != '1) ? seq_q + WIDTH'(1) : seq_q;
    rc_d    = (redir_d && rc_q != '1) ? rc_q + WIDTH'(1) : rc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redir_q <= 1'b0;
      seq_q   <= '0;
      rc_q    <= '0;
    end else begin
      redir_q <= redir_d;
      seq_q   <= seq_d;
      rc_q    <= rc_d;
    end
  end
  assign redirect    = redir_q;
  assign seq_count   = seq_q;
  assign redir_count = rc_q;
`ifndef SYNTHESIS
  always @(posedge clk) begin
    #2;
    $display("%0d", q);
  end
`endif
`else
  assign redirect    = 1'b0;
  assign seq_count   = '0;
  assign redir_count = '0;
`endif
endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: directed checks of pc_reg (32-bit instance) plus a 4-bit instance for counter saturation.
module tb_pc_reg;
`ifdef PC_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  logic        clk = 1'b0, run = 1'b0, reset = 1'b0, rst2 = 1'b0;
  logic [31:0] d = 32'h40, q, q_prev, seq_count, redir_count;
  logic        misaligned, redirect;
  logic [3:0]  d2 = 4'h0, q2, q_prev2, seq2, redir2;
  logic        mis2, redirect2;
  int          checks = 0, errors = 0;

  pc_reg dut (
    .clk(clk), .reset(reset), .d(d), .q(q), .q_prev(q_prev), .misaligned(misaligned),
    .redirect(redirect), .seq_count(seq_count), .redir_count(redir_count)
  );

  pc_reg #(.WIDTH(4), .RESET_VALUE(4'h6), .STEP(4)) dut2 (
    .clk(clk), .reset(rst2), .d(d2), .q(q2), .q_prev(q_prev2), .misaligned(mis2),
    .redirect(redirect2), .seq_count(seq2), .redir_count(redir2)
  );

  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] eq, input logic [31:0] eprev,
                           input logic emis, input logic ered, input logic [31:0] eseq,
                           input logic [31:0] erc);
    check({tag, ".q"}, q, eq);
    check({tag, ".q_prev"}, q_prev, eprev);
    check({tag, ".misaligned"}, 32'(misaligned), 32'(emis));
    check({tag, ".redirect"}, 32'(redirect), TR ? 32'(ered) : 32'd0);
    check({tag, ".seq_count"}, seq_count, TR ? eseq : 32'd0);
    check({tag, ".redir_count"}, redir_count, TR ? erc : 32'd0);
  endtask

  initial begin
    logic [3:0] e2;
    #1;
    reset = 1'b1;
    rst2  = 1'b1;
    #1;
    check_all("reset_idle", 32'h0, 32'h0, 1'b0, 1'b0, 0, 0);
    check("reset2.q", 32'(q2), 32'h6);
    check("reset2.misaligned", 32'(mis2), 32'd1);
    run = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset_clocked", 32'h0, 32'h0, 1'b0, 1'b0, 0, 0);
    // sequential run from 0
    reset = 1'b0;
    d = 32'd4;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_all($sformatf("seq%0d", i), 32'(4 * i), 32'(4 * (i - 1)), 1'b0, 1'b0, 32'(i), 0);
      d = 32'(4 * (i + 1));
    end
    d = 32'h100;
    @(negedge clk);
    check_all("redir_jump", 32'h100, 32'd20, 1'b0, 1'b1, 5, 1);
    d = 32'h104;
    @(negedge clk);
    check_all("redir_after", 32'h104, 32'h100, 1'b0, 1'b0, 6, 1);
    // asynchronous reset between edges
    d = 32'h40;
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    reset <= 1'b0;
    #1;
    check_all("release_edge", 32'h0, 32'h0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_all("first_load", 32'h40, 32'h0, 1'b0, 1'b1, 0, 1);
    // wraparound and alignment
    d = 32'hFFFF_FFFC;
    @(negedge clk);
    check_all("top", 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1, 0, 2);
    d = 32'h0;
    @(negedge clk);
    check_all("wrap", 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1, 2);
    d = 32'h102;
    @(negedge clk);
    check_all("misalign", 32'h102, 32'h0, 1'b1, 1'b1, 1, 3);
    d = 32'h106;
    @(negedge clk);
    check_all("misalign_seq", 32'h106, 32'h102, 1'b1, 1'b0, 2, 3);
    d = 32'h108;
    @(negedge clk);
    check_all("realign", 32'h108, 32'h106, 1'b0, 1'b1, 2, 4);
    @(negedge clk);
    check_all("self_loop", 32'h108, 32'h108, 1'b0, 1'b1, 2, 5);
    // saturation on the 4-bit instance
    rst2 = 1'b0;
    e2 = 4'h6;
    for (int i = 1; i <= 20; i++) begin
      d2 = e2 + 4'd4;
      @(negedge clk);
      e2 = e2 + 4'd4;
      check($sformatf("sat%0d.q", i), 32'(q2), 32'(e2));
      check($sformatf("sat%0d.seq", i), 32'(seq2), TR ? 32'(i > 15 ? 15 : i) : 32'd0);
      check($sformatf("sat%0d.redir", i), 32'(redir2), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_reg.md
# pc_reg

Program-counter register for the single-cycle MIPS datapath. It holds the current instruction address and drives it to instruction fetch and the PC+4 adder. On every rising clock edge it loads the next-address input selected upstream. It also provides alignment and control-flow status for debug.

## Interface
Parameters:
- WIDTH, 32, address width in bits; first positional parameter.
- RESET_VALUE, 0, value loaded into q on reset.
- STEP, 4, sequential increment used to classify a load as sequential or redirect.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- d  input  WIDTH  next PC value.
- q  output  WIDTH  current PC (registered).
- q_prev  output  WIDTH  PC value held before the most recent load.
- misaligned  output  1  high when q[1:0] != 0.
- redirect  output  1  high when the last load was not q+STEP (branch or jump taken).
- seq_count  output  WIDTH  number of sequential loads since reset.
- redir_count  output  WIDTH  number of redirect loads since reset.

## Operation
- Every rising edge of clk with reset low:
  - q <= d
  - q_prev <= q
  - redirect <= (d != q + STEP)
- The sum q + STEP is computed modulo 2^WIDTH. A load of 0 from q = 2^WIDTH-4 counts as sequential.
- misaligned is combinational from q: q[1:0] != 0. No correction is applied; q holds d exactly.
- Counters: seq_count increments on each sequential load and redir_count on each redirect load. Both saturate at all-ones and do not wrap.
- d equal to q (self-loop) is a redirect whenever STEP != 0.
- No enable or stall: the register loads on every edge outside reset.

## Timing
- Reset asserted: immediately, independent of clk:
  - q = RESET_VALUE
  - q_prev = RESET_VALUE
  - redirect = 0
  - seq_count = 0
  - redir_count = 0
  - misaligned follows RESET_VALUE[1:0].
- While reset is high, clock edges have no effect.
- Reset release: the first rising edge with reset low performs the first load.
  - A release coinciding with an edge is treated as still in reset: no load on that edge.
- Latency: d to q is one cycle. q_prev, redirect and both counters update on the same edge as q. misaligned has zero latency from q.
- Reset asserted mid-run clears all state within the same time step, without waiting for an edge.

## Configuration
- PC_TRACE_EN defined:
  - redirect, seq_count and redir_count operate as specified.
  - A simulation-only monitor prints q in decimal 2 time units after each rising edge.
- PC_TRACE_EN undefined:
  - redirect, seq_count and redir_count are tied to 0 and no counter logic is generated.
  - No monitor output.
  - q, q_prev and misaligned are unaffected.

## Test plan
- Reset: assert reset with clk idle, d = 0x40 -> q = 0, q_prev = 0, counts 0 and redirect 0 immediately; toggle clk with reset high -> q stays 0.
- Sequential: release reset, drive d = q+4 for 5 edges -> q = 4, 8, 12, 16, 20; q_prev lags by one cycle; seq_count = 5; redirect = 0 (PC_TRACE_EN).
- Redirect: from q = 20 drive d = 0x100 -> q = 0x100, q_prev = 20, redirect = 1, redir_count = 1; next d = 0x104 -> redirect = 0.
- Wrap and alignment: q = 0xFFFFFFFC, d = 0 -> sequential, redirect = 0; d = 0x102 -> misaligned = 1 on the same cycle q updates.
- Async reset mid-run: q = 0x104, raise reset between edges -> q = 0 and counters 0 without an edge; deassert together with an edge -> no load on that edge.
- Build without PC_TRACE_EN: repeat the redirect test -> redirect and counters stay 0; q and q_prev identical to the traced build.
